// File: rtl/microcode_sequencer.sv
// microcode_sequencer: fetches instructions, dispatches into microcode and steps the ROM emitting datapath control
// Ports: clk/rst (sync active-high); fetch_req/fetch_ready/fetch_data fetch handshake; instruction to decoder,
// dispatch_addr back from decoder; rom_addr/rom_data synchronous microcode ROM; mem_ready completes mem_wait steps;
// cond selects conditional micro-jumps; control/control_valid datapath drive; stall, instr_done, retired status.
module microcode_sequencer #(
  parameter int CTRL_W = 23,
  parameter int UPC_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fetch_req,
  input  logic              fetch_ready,
  input  logic [31:0]       fetch_data,
  output logic [31:0]       instruction,
  input  logic [UPC_W-1:0]  dispatch_addr,
  output logic [UPC_W-1:0]  rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              mem_ready,
  input  logic              cond,
  output logic [CTRL_W-1:0] control,
  output logic              control_valid,
  output logic              stall,
  output logic              instr_done,
  output logic [31:0]       retired
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC} state_t;
  state_t state, state_nx;
  logic [UPC_W-1:0] upc, upc_inc, target;
  logic [1:0] seq;
  logic ex, fin;
  // rom_addr always carries next cycle's upc, so the upc register simply follows it
  always_comb begin
    seq = rom_data[31:30];
    ex = (state == EXEC) && !rst;
    upc_inc = upc + 1'b1;
    target = (seq == 2'b01 || (seq == 2'b11 && cond)) ? rom_data[24 +: UPC_W] : (seq == 2'b10 ? upc : upc_inc);
    stall = ex & rom_data[23] & ~mem_ready;
    fin = ex & ~stall & (seq == 2'b10);
    instr_done = fin;
    control_valid = ex;
    control = ex ? rom_data[CTRL_W-1:0] : '0;
    fetch_req = (state == FETCH) && !rst;
    rom_addr = rst ? '0 : (state == DECODE) ? dispatch_addr : (ex && !stall) ? target : upc;
    state_nx = (fetch_req && fetch_ready) ? DECODE : (state == DECODE) ? EXEC : fin ? FETCH : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      upc <= '0;
      instruction <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      upc <= rom_addr;
      if (fetch_req && fetch_ready) instruction <= fetch_data;
      retired <= retired + {31'b0, fin};
    end
  end
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: directed checks of fetch, dispatch, micro-jumps, stalls, wrap and retire counting
module tb_microcode_sequencer;
  logic clk = 0, rst = 1, fetch_ready = 0, mem_ready = 1, cond = 0;
  logic [31:0] fetch_data = 0, rom_data, instruction, retired;
  logic [5:0] rom_addr;
  logic [22:0] control;
  logic fetch_req, control_valid, stall, instr_done;
  logic [31:0] rom [64];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_data <= rom[rom_addr];
  microcode_sequencer dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .instruction(instruction), .dispatch_addr(instruction[5:0]), .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_ready(mem_ready), .cond(cond), .control(control), .control_valid(control_valid), .stall(stall),
    .instr_done(instr_done), .retired(retired)
  );
  function automatic logic [31:0] uw(input logic [1:0] s, input logic [5:0] n, input logic m, input logic [22:0] c);
    return {s, n, m, c};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  task automatic fetch(input logic [31:0] w);
    fetch_ready = 1;
    fetch_data = w;
    cyc;
    fetch_ready = 0;
    fetch_data = 32'hdeadbeef;
    chk("decode_instr", instruction, w);
    chk("decode_addr", rom_addr, w & 32'h3f);
    chk("decode_req", fetch_req, 0);
    chk("decode_valid", control_valid, 0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = uw(2'b10, 0, 0, 0);
    rom[3] = uw(2'b00, 0, 0, 1);
    rom[4] = uw(2'b10, 0, 0, 2);
    for (int i = 8; i < 11; i++) rom[i] = uw(2'b00, 0, 0, 23'(i));
    rom[11] = uw(2'b10, 0, 0, 11);
    rom[6'h12] = uw(2'b11, 6'h20, 0, 23'h12);
    rom[6'h13] = uw(2'b10, 0, 0, 23'h13);
    rom[6'h20] = uw(2'b10, 0, 0, 23'h20);
    rom[6'h28] = uw(2'b10, 0, 1, 23'h28);
    rom[6'h30] = uw(2'b00, 0, 1, 23'h30);
    rom[6'h31] = uw(2'b10, 0, 0, 23'h31);
    rom[63] = uw(2'b00, 0, 0, 23'h3f);
    repeat (2) cyc;
    chk("rst_req", fetch_req, 0);
    chk("rst_addr", rom_addr, 0);
    rst = 0;
    #1;
    chk("post_rst_req", fetch_req, 1);
    chk("post_rst_valid", control_valid, 0);
    chk("post_rst_retired", retired, 0);
    chk("post_rst_instr", instruction, 0);
    fetch(8);
    cyc;
    chk("ex1_ctrl", control, 8);
    cyc;
    chk("ex2_ctrl", control, 9);
    rst = 1;
    cyc;
    chk("midrst_instr", instruction, 0);
    chk("midrst_retired", retired, 0);
    chk("midrst_done", instr_done, 0);
    rst = 0;
    #1;
    chk("midrst_req", fetch_req, 1);
    chk("midrst_valid", control_valid, 0);
    chk("midrst_addr", rom_addr, 0);
    fetch(3);
    cyc;
    chk("a_ctrl1", control, 1);
    chk("a_valid1", control_valid, 1);
    chk("a_done1", instr_done, 0);
    chk("a_addr1", rom_addr, 4);
    cyc;
    chk("a_ctrl2", control, 2);
    chk("a_done2", instr_done, 1);
    cyc;
    chk("a_retired", retired, 1);
    chk("a_req", fetch_req, 1);
    chk("a_valid3", control_valid, 0);
    cond = 1;
    fetch(32'h12);
    cyc;
    chk("c1_ctrl", control, 23'h12);
    chk("c1_addr", rom_addr, 6'h20);
    cyc;
    chk("c1_tgt", control, 23'h20);
    chk("c1_done", instr_done, 1);
    cyc;
    cond = 0;
    fetch(32'h12);
    cyc;
    chk("c0_addr", rom_addr, 6'h13);
    cyc;
    chk("c0_tgt", control, 23'h13);
    chk("c0_done", instr_done, 1);
    cyc;
    chk("c_retired", retired, 3);
    mem_ready = 0;
    fetch(32'h30);
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("mw_stall", stall, 1);
      chk("mw_ctrl", control, 23'h30);
      chk("mw_addr", rom_addr, 6'h30);
      chk("mw_valid", control_valid, 1);
    end
    mem_ready = 1;
    #1;
    chk("mw_go_stall", stall, 0);
    chk("mw_go_ctrl", control, 23'h30);
    chk("mw_go_addr", rom_addr, 6'h31);
    cyc;
    chk("mw_next", control, 23'h31);
    chk("mw_done", instr_done, 1);
    cyc;
    mem_ready = 0;
    fetch(32'h28);
    repeat (2) begin
      cyc;
      chk("es_stall", stall, 1);
      chk("es_done", instr_done, 0);
    end
    mem_ready = 1;
    #1;
    chk("es_done_go", instr_done, 1);
    cyc;
    chk("es_req", fetch_req, 1);
    chk("es_retired", retired, 5);
    fetch(32'h3f);
    cyc;
    chk("wr_ctrl", control, 23'h3f);
    chk("wr_addr", rom_addr, 0);
    cyc;
    chk("wr_ctrl0", control, 0);
    chk("wr_valid", control_valid, 1);
    chk("wr_done", instr_done, 1);
    cyc;
    for (int i = 0; i < 5; i++) begin
      fetch_data = 32'h100 + i;
      cyc;
      chk("fw_req", fetch_req, 1);
      chk("fw_instr", instruction, 32'h3f);
      chk("fw_valid", control_valid, 0);
    end
    fetch_ready = 1;
    fetch_data = 3;
    repeat (12) cyc;
    fetch_ready = 0;
    chk("b2b_retired", retired, 9);
    chk("b2b_req", fetch_req, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Control sequencer that drives the microcoded RISC-V core: it fetches instruction words, presents each latched instruction to the instruction decoder, and loads the decoder's 6-bit dispatch address into a micro-PC. It then steps through the microcode ROM one word per cycle, emitting datapath control bits, until the microprogram signals end-of-instruction. It sits between the fetch port, the instruction decoder/microcode ROM pair and the execute datapath.

## Interface
Parameters:
- CTRL_W, 23, width of datapath control field (microcode word bits [22:0])
- UPC_W, 6, micro-PC / ROM address width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- fetch_req  out  1  request next instruction word
- fetch_ready  in  1  fetch_data valid; transfer when fetch_req & fetch_ready
- fetch_data  in  32  instruction word from memory
- instruction  out  32  latched instruction, fed to decoder
- dispatch_addr  in  6  decoder's microcode entry point for `instruction`
- rom_addr  out  6  microcode ROM address (ROM is synchronous, 1-cycle read)
- rom_data  in  32  microcode word for previous cycle's rom_addr
- mem_ready  in  1  data-memory completion for mem_wait steps
- cond  in  1  datapath branch condition for conditional micro-jumps
- control  out  CTRL_W  datapath control bits
- control_valid  out  1  control is live this cycle
- stall  out  1  current micro-step held waiting on mem_ready
- instr_done  out  1  one-cycle pulse on final micro-step
- retired  out  32  count of completed instructions

## Operation
- Microcode word: [31:30] seq (00 next, 01 jump, 10 end, 11 cond-jump), [29:24] next_addr, [23] mem_wait, [22:0] control.
- States: FETCH, DECODE, EXEC.
- FETCH: fetch_req=1. On fetch_req & fetch_ready: instruction <= fetch_data, go DECODE. Otherwise hold.
- DECODE (exactly 1 cycle): rom_addr = dispatch_addr (combinational from latched instruction), upc <= dispatch_addr, go EXEC.
- EXEC: control = rom_data[22:0], control_valid=1. Stall = rom_data[23] & ~mem_ready. If stall: rom_addr = upc, upc held, state held. Else next address by seq: 00 → upc+1; 01 → next_addr; 11 → cond ? next_addr : upc+1; 10 → instr_done=1, retired += 1, go FETCH (rom_addr = upc, don't-care).
- upc+1 wraps modulo 64 (63 → 0).
- rom_addr is combinational and equals the upc value that will hold next cycle, so rom_data in EXEC always matches upc.
- Dispatch address 0 (no-op/illegal) is not special-cased; ROM word 0 must encode seq=10 with control=0.
- retired wraps 0xFFFFFFFF → 0.
- Outside EXEC: control=0, control_valid=0, stall=0, instr_done=0.

## Timing
- Reset values: state FETCH, upc 0, instruction 0, retired 0, rom_addr 0, fetch_req 0 while rst high, control 0, control_valid 0, stall 0, instr_done 0.
- rst sampled at posedge overrides all activity, including mid-EXEC and mid-stall. No instr_done and no retired increment on that edge.
- Fetch accepted at edge t → DECODE in cycle t+1 → first control word in cycle t+2.
- An N-step microprogram with no stalls occupies N EXEC cycles. Total instruction latency = fetch wait + 1 + N; with fetch_ready tied high, throughput is one instruction per N+2 cycles.
- instr_done is asserted in the same cycle as the final control word. fetch_req rises the next cycle.
- Stall on an end word (seq=10 with mem_wait) delays instr_done until mem_ready=1.
- mem_ready is ignored when mem_wait=0. cond is sampled only when seq=11 and there is no stall.
- fetch_data is ignored when fetch_req=0.

## Test plan
- Reset mid-EXEC at step 2 of a 4-step program → next cycle state FETCH, control_valid=0, retired unchanged, instruction=0.
- fetch_ready high, dispatch 0x03 to ROM[3]={seq 00}, ROM[4]={seq 10}, control 0x1 then 0x2 → control 0x1 at t+2, 0x2 with instr_done at t+3, retired=1, fetch_req at t+4.
- Cond jump: ROM[0x12]={seq 11, next_addr 0x20} with cond=1 → upc 0x20. Repeat with cond=0 → upc 0x13.
- mem_wait step with mem_ready low for 3 cycles → stall=1 and identical control for 4 cycles, rom_addr constant, advance on the 4th.
- Wrap: ROM[63]={seq 00}, ROM[0]={seq 10} → after 63, rom_addr=0, then instr_done.
- fetch_ready low for 5 cycles → fetch_req held high, instruction unchanged, no control_valid. Retire 3 instructions back to back → retired=3.
